// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port 16-bit-word memory between the fetch stage (read-only)
// and the memory stage (load/store). One access is granted per cycle. The data
// side normally wins, but a fetch request that has been denied STARVE_MAX cycles
// in a row is forced through. Read data has a 1-cycle latency and is routed back
// to whichever side issued the read. Requesters that lose see !gnt and stall.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   f_req_i/f_addr_i      fetch read request and word address
//   f_kill_i              flush: discard any pending fetch response
//   f_gnt_o               fetch access issued this cycle (combinational)
//   f_rvalid_o/f_rdata_o  fetch read response
//   d_req_i/d_we_i        data request; d_we_i=1 store, 0 load
//   d_addr_i/d_wdata_i    data address and store data
//   d_gnt_o               data access issued this cycle (combinational)
//   d_rvalid_o/d_rdata_o  load response
//   mem_*_o               memory command (combinational)
//   mem_rdata_i           memory read data, valid the cycle after a read enable
module mem_port_arbiter #(
    parameter int AW         = 16,
    parameter int STARVE_MAX = 3
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          f_req_i,
    input  logic [AW-1:0] f_addr_i,
    input  logic          f_kill_i,
    output logic          f_gnt_o,
    output logic          f_rvalid_o,
    output logic [15:0]   f_rdata_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [15:0]   d_wdata_i,
    output logic          d_gnt_o,
    output logic          d_rvalid_o,
    output logic [15:0]   d_rdata_o,
    output logic          mem_en_o,
    output logic          mem_we_o,
    output logic [AW-1:0] mem_addr_o,
    output logic [15:0]   mem_wdata_o,
    input  logic [15:0]   mem_rdata_i
);

    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM  = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE  = SW'(1);
    localparam logic [SW-1:0] STARVE_ZERO = SW'(0);

    // Owner of the read response arriving next cycle.
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_FETCH = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;

    logic [SW-1:0] starve_q, starve_d;
    logic [1:0]    owner_q, owner_d;
    logic          force_f_s;
    logic          f_gnt_s;
    logic          d_gnt_s;
    logic          f_rvalid_s;
    logic          d_rvalid_s;

    // Grant decision: data wins unless fetch has hit its starvation limit.
    always_comb begin
        force_f_s = f_req_i && (starve_q == STARVE_LIM);
        d_gnt_s   = !rst_i && d_req_i && !force_f_s;
        f_gnt_s   = !rst_i && f_req_i && !d_gnt_s;
    end

    assign f_gnt_o = f_gnt_s;
    assign d_gnt_o = d_gnt_s;

    // Memory command mux; drives zeros when no access is issued.
    always_comb begin
        mem_en_o    = f_gnt_s | d_gnt_s;
        mem_we_o    = d_gnt_s && d_we_i;
        mem_addr_o  = {AW{1'b0}};
        mem_wdata_o = 16'h0000;
        if (d_gnt_s) begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
        end else if (f_gnt_s) begin
            mem_addr_o  = f_addr_i;
        end else begin
            mem_addr_o  = {AW{1'b0}};
            mem_wdata_o = 16'h0000;
        end
    end

    // Starvation counter next state: counts consecutive denied fetch cycles.
    always_comb begin
        starve_d = STARVE_ZERO;
        if (f_req_i && !f_gnt_s) begin
            if (starve_q == STARVE_LIM) begin
                starve_d = STARVE_LIM;
            end else begin
                starve_d = starve_q + STARVE_ONE;
            end
        end else begin
            starve_d = STARVE_ZERO;
        end
    end

    // Response owner next state; a fetch killed in its grant cycle still
    // uses the memory slot but leaves no response owner behind.
    always_comb begin
        owner_d = OWN_NONE;
        if (f_gnt_s && !f_kill_i) begin
            owner_d = OWN_FETCH;
        end else if (d_gnt_s && !d_we_i) begin
            owner_d = OWN_DATA;
        end else begin
            owner_d = OWN_NONE;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_q <= STARVE_ZERO;
            owner_q  <= OWN_NONE;
        end else begin
            starve_q <= starve_d;
            owner_q  <= owner_d;
        end
    end

    // Response routing: read data passes straight through to its owner.
    // Reset hides any response still in flight; a kill in the response
    // cycle suppresses only the fetch side.
    always_comb begin
        f_rvalid_s = 1'b0;
        d_rvalid_s = 1'b0;
        case (owner_q)
            OWN_FETCH: f_rvalid_s = !rst_i && !f_kill_i;
            OWN_DATA:  d_rvalid_s = !rst_i;
            OWN_NONE:  begin
                f_rvalid_s = 1'b0;
                d_rvalid_s = 1'b0;
            end
            default:   begin
                f_rvalid_s = 1'b0;
                d_rvalid_s = 1'b0;
            end
        endcase
    end

    assign f_rvalid_o = f_rvalid_s;
    assign d_rvalid_o = d_rvalid_s;
    assign f_rdata_o  = f_rvalid_s ? mem_rdata_i : 16'h0000;
    assign d_rdata_o  = d_rvalid_s ? mem_rdata_i : 16'h0000;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_req, f_kill, d_req, d_we;
    logic [15:0] f_addr, d_addr, d_wdata;
    logic        f_gnt, f_rvalid, d_gnt, d_rvalid, mem_en, mem_we;
    logic [15:0] f_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        pl_we;
    logic [9:0]  pl_addr;
    logic [15:0] pl_data;
    logic [15:0] mem [0:1023];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(16), .STARVE_MAX(3)) dut (
        .clk_i(clk), .rst_i(rst),
        .f_req_i(f_req), .f_addr_i(f_addr), .f_kill_i(f_kill),
        .f_gnt_o(f_gnt), .f_rvalid_o(f_rvalid), .f_rdata_o(f_rdata),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata),
        .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
        .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata)
    );

    // Memory model: 1-cycle read latency, plus a bench-only preload port.
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_en && mem_we) mem[mem_addr[9:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[9:0]];
    end

    // Apply one cycle of inputs at the falling edge, then settle.
    task automatic drive(input logic fr, input logic [15:0] fa, input logic fk,
                         input logic dr, input logic dw, input logic [15:0] da,
                         input logic [15:0] dwd);
        @(negedge clk);
        f_req = fr; f_addr = fa; f_kill = fk;
        d_req = dr; d_we = dw; d_addr = da; d_wdata = dwd;
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic preload(input logic [9:0] a, input logic [15:0] v);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = v;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 16'h0010, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
        checks++; if (f_gnt !== 1'b0 || d_gnt !== 1'b0) begin failures++;
            $display("FAIL rst_gnt got f=%0b d=%0b exp 0 0", f_gnt, d_gnt); end
        checks++; if (mem_en !== 1'b0 || mem_addr !== 16'h0000) begin failures++;
            $display("FAIL rst_mem got en=%0b addr=%h exp 0 0000", mem_en, mem_addr); end
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0 || f_rdata !== 16'h0000 || d_rdata !== 16'h0000) begin failures++;
            $display("FAIL rst_rvalid got f=%0b d=%0b fd=%h dd=%h exp zeros", f_rvalid, d_rvalid, f_rdata, d_rdata); end
        @(posedge clk); #1;
        checks++; if (dut.starve_q !== 2'd0) begin failures++;
            $display("FAIL rst_starve got=%0d exp=0", dut.starve_q); end
        rst = 1'b0;
        idle();
    endtask

    task automatic test_fetch_only();
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (f_gnt !== 1'b1 || d_gnt !== 1'b0) begin failures++;
            $display("FAIL t1_gnt got f=%0b d=%0b exp 1 0", f_gnt, d_gnt); end
        checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 16'h0010) begin failures++;
            $display("FAIL t1_mem got en=%0b we=%0b addr=%h exp 1 0 0010", mem_en, mem_we, mem_addr); end
        checks++; if (f_rvalid !== 1'b0) begin failures++;
            $display("FAIL t1_early got=%0b exp=0", f_rvalid); end
        idle();
        checks++; if (f_rvalid !== 1'b1 || f_rdata !== 16'hBEEF) begin failures++;
            $display("FAIL t1_resp got v=%0b d=%h exp 1 BEEF", f_rvalid, f_rdata); end
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 16'h0000 || mem_en !== 1'b0 || mem_addr !== 16'h0000) begin failures++;
            $display("FAIL t1_other got dv=%0b dd=%h en=%0b addr=%h exp 0 0 0 0", d_rvalid, d_rdata, mem_en, mem_addr); end
        idle();
        checks++; if (f_rvalid !== 1'b0) begin failures++;
            $display("FAIL t1_single got=%0b exp=0", f_rvalid); end
    endtask

    task automatic test_starvation();
        logic exp_dg [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
        int   exp_st [5] = '{1, 2, 3, 0, 1};
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
            checks++; if (d_gnt !== exp_dg[i] || f_gnt !== !exp_dg[i]) begin failures++;
                $display("FAIL t2_gnt[%0d] got d=%0b f=%0b exp d=%0b", i, d_gnt, f_gnt, exp_dg[i]); end
            checks++; if (mem_addr !== (exp_dg[i] ? 16'h0200 : 16'h0020)) begin failures++;
                $display("FAIL t2_addr[%0d] got=%h", i, mem_addr); end
            if (i > 0) begin
                checks++; if (d_rvalid !== exp_dg[i-1] || f_rvalid !== !exp_dg[i-1] ||
                              (exp_dg[i-1] ? d_rdata : f_rdata) !== (exp_dg[i-1] ? 16'hA5A5 : 16'h1111)) begin failures++;
                    $display("FAIL t2_resp[%0d] got dv=%0b fv=%0b dd=%h fd=%h", i, d_rvalid, f_rvalid, d_rdata, f_rdata); end
            end
            @(posedge clk); #1;
            checks++; if (int'(dut.starve_q) !== exp_st[i]) begin failures++;
                $display("FAIL t2_starve[%0d] got=%0d exp=%0d", i, dut.starve_q, exp_st[i]); end
        end
        idle();
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 16'hA5A5 || f_rvalid !== 1'b0) begin failures++;
            $display("FAIL t2_tail got dv=%0b dd=%h fv=%0b exp 1 A5A5 0", d_rvalid, d_rdata, f_rvalid); end
        idle();
    endtask

    task automatic test_store_load();
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h0300, 16'h1234);
        checks++; if (d_gnt !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 16'h0300 || mem_wdata !== 16'h1234) begin failures++;
            $display("FAIL t3_store got g=%0b we=%0b a=%h wd=%h exp 1 1 0300 1234", d_gnt, mem_we, mem_addr, mem_wdata); end
        drive(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0300, 16'h0000);
        checks++; if (d_rvalid !== 1'b0 || mem_we !== 1'b0 || d_gnt !== 1'b1 || mem_wdata !== 16'h0000) begin failures++;
            $display("FAIL t3_load got rv=%0b we=%0b g=%0b wd=%h exp 0 0 1 0000", d_rvalid, mem_we, d_gnt, mem_wdata); end
        idle();
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 16'h1234 || f_rvalid !== 1'b0) begin failures++;
            $display("FAIL t3_resp got v=%0b d=%h fv=%0b exp 1 1234 0", d_rvalid, d_rdata, f_rvalid); end
    endtask

    task automatic test_kill();
        drive(1'b1, 16'h0010, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (f_gnt !== 1'b1) begin failures++;
            $display("FAIL t4_gnt1 got=%0b exp=1", f_gnt); end
        drive(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0200, 16'h0000);
        checks++; if (f_rvalid !== 1'b0 || f_rdata !== 16'h0000) begin failures++;
            $display("FAIL t4_kill_resp got v=%0b d=%h exp 0 0000", f_rvalid, f_rdata); end
        checks++; if (d_gnt !== 1'b1 || mem_addr !== 16'h0200) begin failures++;
            $display("FAIL t4_dgnt got g=%0b a=%h exp 1 0200", d_gnt, mem_addr); end
        drive(1'b1, 16'h0010, 1'b1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        checks++; if (d_rvalid !== 1'b1 || d_rdata !== 16'hA5A5) begin failures++;
            $display("FAIL t4_dresp got v=%0b d=%h exp 1 A5A5", d_rvalid, d_rdata); end
        checks++; if (f_gnt !== 1'b1 || mem_en !== 1'b1 || mem_addr !== 16'h0010) begin failures++;
            $display("FAIL t4_gnt2 got g=%0b en=%0b a=%h exp 1 1 0010", f_gnt, mem_en, mem_addr); end
        idle();
        checks++; if (f_rvalid !== 1'b0 || d_rvalid !== 1'b0) begin failures++;
            $display("FAIL t4_kill_grant got fv=%0b dv=%0b exp 0 0", f_rvalid, d_rvalid); end
        idle();
    endtask

    task automatic test_reset_inflight();
        drive(1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
        drive(1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
        checks++; if (d_gnt !== 1'b1) begin failures++;
            $display("FAIL t5_gnt got=%0b exp=1", d_gnt); end
        rst = 1'b1;
        drive(1'b1, 16'h0020, 1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000);
        checks++; if (d_rvalid !== 1'b0 || d_rdata !== 16'h0000 || d_gnt !== 1'b0 || f_gnt !== 1'b0) begin failures++;
            $display("FAIL t5_rst got dv=%0b dd=%h dg=%0b fg=%0b exp zeros", d_rvalid, d_rdata, d_gnt, f_gnt); end
        @(posedge clk); #1;
        checks++; if (dut.starve_q !== 2'd0) begin failures++;
            $display("FAIL t5_starve got=%0d exp=0", dut.starve_q); end
        rst = 1'b0;
        idle();
        checks++; if (d_rvalid !== 1'b0 || f_rvalid !== 1'b0) begin failures++;
            $display("FAIL t5_late got dv=%0b fv=%0b exp 0 0", d_rvalid, f_rvalid); end
    endtask

    task automatic test_back_to_back();
        logic        isf [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [15:0] adr [4] = '{16'h0010, 16'h0200, 16'h0030, 16'h0020};
        logic [15:0] dat [4] = '{16'hBEEF, 16'hA5A5, 16'h2222, 16'h1111};
        for (int i = 0; i < 5; i++) begin
            if (i < 4) drive(isf[i], adr[i], 1'b0, !isf[i], 1'b0, adr[i], 16'h0000);
            else idle();
            if (i < 4) begin
                checks++; if (f_gnt !== isf[i] || d_gnt !== !isf[i] || mem_addr !== adr[i]) begin failures++;
                    $display("FAIL t6_gnt[%0d] got f=%0b d=%0b a=%h exp f=%0b a=%h", i, f_gnt, d_gnt, mem_addr, isf[i], adr[i]); end
            end
            if (i > 0) begin
                checks++; if (f_rvalid !== isf[i-1] || d_rvalid !== !isf[i-1] ||
                              (isf[i-1] ? f_rdata : d_rdata) !== dat[i-1]) begin failures++;
                    $display("FAIL t6_resp[%0d] got fv=%0b dv=%0b fd=%h dd=%h exp data %h", i, f_rvalid, d_rvalid, f_rdata, d_rdata, dat[i-1]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; pl_we = 1'b0; pl_addr = 10'd0; pl_data = 16'h0000;
        f_req = 1'b0; f_addr = 16'h0000; f_kill = 1'b0;
        d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
        preload(10'h010, 16'hBEEF);
        preload(10'h020, 16'h1111);
        preload(10'h030, 16'h2222);
        preload(10'h200, 16'hA5A5);
        test_reset();
        test_fetch_only();
        test_starvation();
        test_store_load();
        test_kill();
        test_reset_inflight();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
